// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port 8-bit RAM between the CPU bus and a DMA master.
// Each access is sequenced IDLE -> ACCESS -> WAIT -> DONE, and the granted port gets a
// one-cycle ready pulse when the access completes.
// Build macro RAM_ARB_CPU_PRIORITY_EN: when defined, the CPU always wins a tie (fixed
// priority). When undefined (the default), ties alternate round-robin.
module ram_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wr_data,
    output logic [7:0]        cpu_rd_data,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wr_data,
    output logic [7:0]        dma_rd_data,
    output logic              dma_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wr_data,
    output logic              mem_wren,
    input  logic [7:0]        mem_rd_data,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [1:0]        r_wait_cnt;
    logic              r_grant_dma;
    logic              r_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wr_data;
    logic              r_mem_wren;
    logic [7:0]        r_cpu_rd_data;
    logic [7:0]        r_dma_rd_data;
    logic              r_cpu_ready;
    logic              r_dma_ready;
    logic              w_req_any;
    logic              w_grant_dma;

    assign w_req_any = cpu_req | dma_req;

`ifdef RAM_ARB_CPU_PRIORITY_EN
    // Fixed priority: DMA is served only while the CPU is not asking.
    assign w_grant_dma = dma_req & ~cpu_req;
`else
    // 1 = DMA held the last grant; reset to DMA so the CPU wins the first tie.
    logic r_rr_last_dma;

    assign w_grant_dma = dma_req & (~cpu_req | ~r_rr_last_dma);

    // Remember which port was granted last for the round-robin tie-break.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_last_dma <= 1'b1;
        end else if (r_state == StIdle && w_req_any) begin
            r_rr_last_dma <= w_grant_dma;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DONE always returns to IDLE so requests seen there are ignored.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_req_any) w_state_next = StAccess;
            StAccess: w_state_next = StWait;
            StWait:   if (r_wait_cnt == 2'd0) w_state_next = StDone;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Datapath: latch the granted request, time the RAM latency, return data and ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt    <= 2'd0;
            r_grant_dma   <= 1'b0;
            r_we          <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wr_data <= 8'h00;
            r_mem_wren    <= 1'b0;
            r_cpu_rd_data <= 8'h00;
            r_dma_rd_data <= 8'h00;
            r_cpu_ready   <= 1'b0;
            r_dma_ready   <= 1'b0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_dma_ready <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_req_any) begin
                        r_grant_dma   <= w_grant_dma;
                        r_we          <= w_grant_dma ? dma_we : cpu_we;
                        r_mem_addr    <= w_grant_dma ? dma_addr : cpu_addr;
                        r_mem_wr_data <= w_grant_dma ? dma_wr_data : cpu_wr_data;
                        r_mem_wren    <= w_grant_dma ? dma_we : cpu_we;
                    end
                end
                StAccess: begin
                    // Write enable is exactly one cycle wide.
                    r_mem_wren <= 1'b0;
                    r_wait_cnt <= 2'(MEM_LATENCY - 1);
                end
                StWait: begin
                    if (r_wait_cnt == 2'd0) begin
                        // Writes still pulse ready but leave both rd_data registers alone.
                        if (!r_we) begin
                            if (r_grant_dma) begin
                                r_dma_rd_data <= mem_rd_data;
                            end else begin
                                r_cpu_rd_data <= mem_rd_data;
                            end
                        end
                        r_cpu_ready <= ~r_grant_dma;
                        r_dma_ready <= r_grant_dma;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                StDone: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign mem_wren    = r_mem_wren;
    assign cpu_rd_data = r_cpu_rd_data;
    assign dma_rd_data = r_dma_rd_data;
    assign cpu_ready   = r_cpu_ready;
    assign dma_ready   = r_dma_ready;
    assign busy        = (r_state != StIdle);

endmodule
